// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded ID fields for EX and detects load-use hazards.
// On a hazard it inserts one bubble and raises stall. On a branch flush from EX it inserts one bubble.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [1:0]       id_ALUOp,
  input  logic             id_ALUSrc,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [3:0]       id_funct,
  input  logic             flush,
  output logic [1:0]       ex_ALUOp,
  output logic             ex_ALUSrc,
  output logic             ex_branch,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_funct,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Flow contract: ex_valid marks a real instruction in EX. While stall is high, upstream
  // must hold PC and IF/ID so the same ID instruction is presented again next cycle.
  // This register has no hold of its own; every edge loads either ID or a bubble.
  logic use_rs1;
  logic use_rs2;
  logic hazard;
  logic bubble;

  assign use_rs1 = id_valid;
  assign use_rs2 = id_valid & (~id_ALUSrc | id_mem_write);

  assign hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                  ((use_rs1 & (ex_rd == id_rs1)) | (use_rs2 & (ex_rd == id_rs2)));

  // Flush squashes the ID instruction anyway, so it overrides the stall.
  assign stall  = hazard & ~flush;
  assign bubble = flush | stall;

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      ex_valid      <= 1'b0;
      ex_ALUOp      <= 2'b00;
      ex_ALUSrc     <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= 5'd0;
      ex_rs2        <= 5'd0;
      ex_rd         <= 5'd0;
      ex_funct      <= 4'd0;
    end else begin
      ex_valid      <= id_valid;
      ex_ALUOp      <= id_valid ? id_ALUOp : 2'b00;
      ex_ALUSrc     <= id_valid & id_ALUSrc;
      ex_branch     <= id_valid & id_branch;
      ex_mem_read   <= id_valid & id_mem_read;
      ex_mem_write  <= id_valid & id_mem_write;
      ex_reg_write  <= id_valid & id_reg_write;
      ex_mem_to_reg <= id_valid & id_reg_write & id_mem_to_reg;
      ex_pc         <= id_pc;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_funct      <= id_funct;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table, flush saturation sequence on a CNT_W=2 copy,
// and randomized traffic checked against a behavioural model with an expected queue.
module tb_id_ex_pipe_reg;

  localparam int XLEN = 32;
  localparam int EW   = 156;

  // ctrl bit order: [7:6] ALUOp, [5] ALUSrc, [4] branch, [3] mem_read, [2] mem_write, [1] reg_write, [0] mem_to_reg
  typedef struct packed {
    logic        flush;
    logic        valid;
    logic [7:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
  } id_in_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
  } ex_t;

  typedef struct {
    id_in_t      in;
    logic        st;
    logic        valid;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  id_in_t drv;

  logic [1:0]  ex_ALUOp, ex_ALUOp_b;
  logic        ex_ALUSrc, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_valid;
  logic        ex_ALUSrc_b, ex_branch_b, ex_mem_read_b, ex_mem_write_b, ex_reg_write_b, ex_mem_to_reg_b, ex_valid_b;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [31:0] ex_pc_b, ex_rs1_data_b, ex_rs2_data_b, ex_imm_b;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_rs1_b, ex_rs2_b, ex_rd_b;
  logic [3:0]  ex_funct, ex_funct_b;
  logic        stall, stall_b;
  logic [15:0] bubble_cnt;
  logic [1:0]  bubble_cnt_b;
  ex_t         act_ex, act_ex_b;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];
  vec_t tbl[$];
  ex_t  m_ex;
  int   m_cnt;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(drv.valid),
    .id_ALUOp(drv.ctrl[7:6]), .id_ALUSrc(drv.ctrl[5]), .id_branch(drv.ctrl[4]),
    .id_mem_read(drv.ctrl[3]), .id_mem_write(drv.ctrl[2]), .id_reg_write(drv.ctrl[1]),
    .id_mem_to_reg(drv.ctrl[0]), .id_pc(drv.pc), .id_rs1_data(drv.rs1_data),
    .id_rs2_data(drv.rs2_data), .id_imm(drv.imm), .id_rs1(drv.rs1), .id_rs2(drv.rs2),
    .id_rd(drv.rd), .id_funct(drv.funct), .flush(drv.flush),
    .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .stall(stall), .bubble_cnt(bubble_cnt)
  );

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(drv.valid),
    .id_ALUOp(drv.ctrl[7:6]), .id_ALUSrc(drv.ctrl[5]), .id_branch(drv.ctrl[4]),
    .id_mem_read(drv.ctrl[3]), .id_mem_write(drv.ctrl[2]), .id_reg_write(drv.ctrl[1]),
    .id_mem_to_reg(drv.ctrl[0]), .id_pc(drv.pc), .id_rs1_data(drv.rs1_data),
    .id_rs2_data(drv.rs2_data), .id_imm(drv.imm), .id_rs1(drv.rs1), .id_rs2(drv.rs2),
    .id_rd(drv.rd), .id_funct(drv.funct), .flush(drv.flush),
    .ex_ALUOp(ex_ALUOp_b), .ex_ALUSrc(ex_ALUSrc_b), .ex_branch(ex_branch_b), .ex_mem_read(ex_mem_read_b),
    .ex_mem_write(ex_mem_write_b), .ex_reg_write(ex_reg_write_b), .ex_mem_to_reg(ex_mem_to_reg_b),
    .ex_valid(ex_valid_b), .ex_pc(ex_pc_b), .ex_rs1_data(ex_rs1_data_b), .ex_rs2_data(ex_rs2_data_b),
    .ex_imm(ex_imm_b), .ex_rs1(ex_rs1_b), .ex_rs2(ex_rs2_b), .ex_rd(ex_rd_b), .ex_funct(ex_funct_b),
    .stall(stall_b), .bubble_cnt(bubble_cnt_b)
  );

  assign act_ex = {ex_valid, ex_ALUOp, ex_ALUSrc, ex_branch, ex_mem_read, ex_mem_write,
                   ex_reg_write, ex_mem_to_reg, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                   ex_rs1, ex_rs2, ex_rd, ex_funct};
  assign act_ex_b = {ex_valid_b, ex_ALUOp_b, ex_ALUSrc_b, ex_branch_b, ex_mem_read_b, ex_mem_write_b,
                     ex_reg_write_b, ex_mem_to_reg_b, ex_pc_b, ex_rs1_data_b, ex_rs2_data_b, ex_imm_b,
                     ex_rs1_b, ex_rs2_b, ex_rd_b, ex_funct_b};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic id_in_t mk(input logic f, input logic v, input logic [7:0] c,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                input logic [31:0] d);
    id_in_t t;
    t.flush = f; t.valid = v; t.ctrl = c;
    t.pc = d + 32'd4; t.rs1_data = d; t.rs2_data = ~d; t.imm = d ^ 32'h55;
    t.rs1 = r1; t.rs2 = r2; t.rd = rd; t.funct = d[7:4];
    return t;
  endfunction

  function automatic vec_t vr(input id_in_t in, input logic st, input logic v, input logic [7:0] c,
                              input logic [4:0] rd, input logic [31:0] d, input logic [15:0] cnt);
    vec_t r;
    r.in = in; r.st = st; r.valid = v; r.ctrl = c; r.rd = rd; r.d = d; r.cnt = cnt;
    return r;
  endfunction

  // Reference rules: which source registers the ID instruction reads, and when a load in EX blocks it.
  function automatic logic model_stall(input ex_t ex, input id_in_t in);
    logic reads_rs1, reads_rs2, dep;
    reads_rs1 = in.valid;
    reads_rs2 = in.valid && (!in.ctrl[5] || in.ctrl[2]);
    dep = (reads_rs1 && ex.rd == in.rs1) || (reads_rs2 && ex.rd == in.rs2);
    return ex.valid && ex.ctrl[3] && (ex.rd != 5'd0) && dep && !in.flush;
  endfunction

  function automatic ex_t model_next(input ex_t ex, input id_in_t in);
    ex_t n;
    n = '0;
    if (in.flush || model_stall(ex, in)) return n;
    n.valid = in.valid;
    n.ctrl  = in.valid ? in.ctrl : 8'h00;
    if (!n.ctrl[1]) n.ctrl[0] = 1'b0;
    n.pc = in.pc; n.rs1_data = in.rs1_data; n.rs2_data = in.rs2_data; n.imm = in.imm;
    n.rs1 = in.rs1; n.rs2 = in.rs2; n.rd = in.rd; n.funct = in.funct;
    return n;
  endfunction

  task automatic do_reset(input int edges);
    rst_n = 1'b0;
    repeat (edges) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [EW-1:0] e;
    logic exp_st;
    drv   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    drv = {$urandom, $urandom, $urandom, $urandom, $urandom};
    do_reset(2);
    check("reset_ex", act_ex, '0);
    check("reset_cnt", bubble_cnt, 0);
    check("reset_stall", stall, 0);
    check("reset_ex_sat", {act_ex_b, bubble_cnt_b, stall_b}, '0);

    // Directed program: R-type, load-use, x0 load, ADDI with stray rs2, flush vs hazard, invalid slot, SW dependency.
    tbl.push_back(vr(mk(0, 1, 8'h82, 5, 6, 7, 32'h10),  0, 1, 8'h82, 7, 32'h10, 0));
    tbl.push_back(vr(mk(0, 1, 8'h2B, 1, 9, 3, 32'h100), 0, 1, 8'h2B, 3, 32'h100, 0));
    tbl.push_back(vr(mk(0, 1, 8'h82, 3, 1, 4, 32'h200), 1, 0, 8'h00, 0, 32'h0, 1));
    tbl.push_back(vr(mk(0, 1, 8'h82, 3, 1, 4, 32'h200), 0, 1, 8'h82, 4, 32'h200, 1));
    tbl.push_back(vr(mk(0, 1, 8'h2B, 1, 9, 0, 32'h300), 0, 1, 8'h2B, 0, 32'h300, 1));
    tbl.push_back(vr(mk(0, 1, 8'h82, 0, 1, 4, 32'h400), 0, 1, 8'h82, 4, 32'h400, 1));
    tbl.push_back(vr(mk(0, 1, 8'h2B, 1, 9, 3, 32'h500), 0, 1, 8'h2B, 3, 32'h500, 1));
    tbl.push_back(vr(mk(0, 1, 8'hA2, 1, 3, 5, 32'h600), 0, 1, 8'hA2, 5, 32'h600, 1));
    tbl.push_back(vr(mk(0, 1, 8'h2B, 1, 9, 3, 32'h700), 0, 1, 8'h2B, 3, 32'h700, 1));
    tbl.push_back(vr(mk(1, 1, 8'h82, 3, 1, 4, 32'h800), 0, 0, 8'h00, 0, 32'h0, 2));
    tbl.push_back(vr(mk(0, 0, 8'hFF, 3, 3, 9, 32'h900), 0, 0, 8'h00, 9, 32'h900, 2));
    tbl.push_back(vr(mk(0, 1, 8'h2B, 1, 9, 6, 32'hA00), 0, 1, 8'h2B, 6, 32'hA00, 2));
    tbl.push_back(vr(mk(0, 1, 8'h25, 1, 6, 2, 32'hB00), 1, 0, 8'h00, 0, 32'h0, 3));
    tbl.push_back(vr(mk(0, 1, 8'h25, 1, 6, 2, 32'hB00), 0, 1, 8'h24, 2, 32'hB00, 3));

    foreach (tbl[i]) begin
      drv = tbl[i].in;
      #1;
      check($sformatf("tbl%0d_stall", i), stall, tbl[i].st);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_ex", i), {ex_valid, act_ex.ctrl, ex_rd, ex_rs1_data, bubble_cnt},
            {tbl[i].valid, tbl[i].ctrl, tbl[i].rd, tbl[i].d, tbl[i].cnt});
    end

    // Back-to-back flushes: 16-bit counter keeps counting, 2-bit counter pins at 3.
    do_reset(1);
    for (int k = 1; k <= 5; k++) begin
      drv = mk(1, 1, 8'h2B, 1, 2, 3, $urandom);
      @(posedge clk);
      #1;
      check($sformatf("sat_flush%0d", k), {bubble_cnt, bubble_cnt_b, ex_valid},
            {16'(k), 2'((k > 3) ? 3 : k), 1'b0});
    end

    // Random traffic; a stalled ID instruction is held, as the upstream IF/ID would.
    do_reset(1);
    m_ex  = '0;
    m_cnt = 0;
    exp_st = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (!exp_st) begin
        drv = mk(1'b0, $urandom_range(0, 7) != 0, 8'($urandom),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom);
      end
      drv.flush = ($urandom_range(0, 7) == 0);
      exp_st = model_stall(m_ex, drv);
      #1;
      check("rnd_stall", stall, exp_st);
      if (drv.flush || exp_st) m_cnt++;
      m_ex = model_next(m_ex, drv);
      exp_q.push_back(m_ex);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("rnd_ex", act_ex, e);
      check("rnd_ex_sat", act_ex_b, e);
      check("rnd_cnt", {bubble_cnt, bubble_cnt_b}, {16'(m_cnt), 2'((m_cnt > 3) ? 3 : m_cnt)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register. It sits directly downstream of the ID-stage control decoder and register file, and feeds the EX stage.
- Captures decoded control bits, operands, immediate and register indices each cycle.
- Contains load-use hazard detection: it stalls PC and IF/ID and inserts a bubble.
- Honours a branch flush from EX and keeps a saturating count of bubbles.

Parameters:
- XLEN, 32, datapath width for PC, operands and immediate.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_ALUOp  in  2  from control.
- id_ALUSrc, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  from control.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5 each  instruc[19:15], [24:20], [11:7].
- id_funct  in  4  {instruc[30], instruc[14:12]}.
- flush  in  1  branch taken in EX; squash the ID instruction.
- ex_ALUOp  out  2  registered control.
- ex_ALUSrc, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each  registered control.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered.
- ex_funct  out  4  registered.
- stall  out  1  combinational; holds PC and IF/ID this cycle.
- bubble_cnt  out  CNT_W  bubbles inserted since reset.

Behaviour:
- **Reset:** rst_n=0 at a rising edge clears every registered output to 0, including bubble_cnt and ex_valid.
  - stall is combinational from registered state, so it reads 0 the cycle after reset.
- **Latency:** 1 cycle. Values at ID on edge N appear on ex_* after edge N.
- **Register use:**
  - use_rs2 = id_valid & (~id_ALUSrc | id_mem_write), covering R-type, BEQ and SW.
  - use_rs1 = id_valid.
- **Hazard detection (combinational):**
  - hazard = ex_valid & ex_mem_read & (ex_rd != 0) & ((use_rs1 & ex_rd == id_rs1) | (use_rs2 & ex_rd == id_rs2)).
  - stall = hazard & ~flush.
- **Per-edge update, priority order:**
  1. rst_n=0: reset, as above.
  2. flush=1: load a bubble. All control outputs are 0, ex_valid=0, data and index fields are don't-care (the implementation zeroes them), bubble_cnt +1.
  3. stall=1: load a bubble exactly as for flush, bubble_cnt +1. The ID instruction is re-presented next cycle by the held IF/ID.
  4. Otherwise: capture all id_* fields. ex_valid=id_valid.
     - id_valid=0 forces all control outputs to 0, regardless of the control inputs.
     - id_mem_to_reg is forced to 0 whenever id_reg_write=0, so x values never enter EX.
- **Single stall per load-use:** after one bubble, ex_mem_read=0, so hazard clears and the instruction advances on the next edge. A stall never lasts more than one cycle per load.
- **Flush with hazard in the same cycle:** flush wins. stall=0, one bubble, counter +1 (not +2).
- **bubble_cnt:** saturates at 2^CNT_W-1 and never wraps.
- **No write-enable input:** the register never holds its own contents. Holding is done upstream using stall.

Test Plan:
- **Reset:** drive garbage on all inputs, hold rst_n=0 for 2 edges -> all ex_* outputs, stall and bubble_cnt read 0.
- **Pass-through:** R-type add, id_rs1=5, id_rs2=6, id_rd=7, id_rs1_data=0x10, id_rs2_data=0x20 -> next cycle ex_ALUOp=2'b10, ex_reg_write=1, ex_rs1_data=0x10, ex_rd=7, ex_valid=1, stall=0.
- **Load-use:** LW x3 followed by add x4,x3,x1 -> stall=1 for exactly one cycle, one bubble (ex_valid=0, all control 0), bubble_cnt=1. The add reaches EX on the following edge.
- **No false stall:**
  - LW x0 then add x4,x0,x1 -> stall=0.
  - LW x3 then ADDI x5,x1,imm whose instruc[24:20]=3 -> stall=0 (rs2 unused).
- **Flush priority:** load-use hazard and flush=1 in the same cycle -> stall=0, single bubble, bubble_cnt increments by exactly 1.
- **Saturation:** with CNT_W=2, force 5 consecutive flushes -> bubble_cnt stops at 3.
